tictactoe_ctrl: RTL
===================

TICTACTOE_CTRL -- requirements
Module: tictactoe_ctrl

Interface
REQ-001 SHALL have parameter FIRST_X, default 1; 1 = X moves first, 0 = O moves first.
REQ-002 SHALL have parameter TIMEOUT, default 1000; per-move cycle limit (1..65535); 0 disables the timeout.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  single-cycle pulse, clears the board and begins a new game.
REQ-007 move_valid  in  1  move request present.
REQ-008 move_player  in  1  requesting player; 0 = X, 1 = O.
REQ-009 move_pos  in  4  target cell, 0..8, row-major; bit i of the boards corresponds to cell i.
REQ-010 move_ready  out  1  controller can accept a move this cycle.
REQ-011 move_ack  out  1  one-cycle pulse, legal move committed.
REQ-012 move_err  out  1  one-cycle pulse, move rejected.
REQ-013 x_board  out  9  cells held by X (registered).
REQ-014 o_board  out  9  cells held by O (registered).
REQ-015 turn  out  1  player to move; 0 = X, 1 = O.
REQ-016 game_over  out  1  high while in DONE.
REQ-017 winner  out  2  00 = none, 01 = X, 10 = O, 11 = draw; valid while game_over.
REQ-018 forfeit  out  1  high in DONE when the game ended by timeout.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT_MOVE, EVAL and DONE.
REQ-020 IDLE: move_ready=0; start -> WAIT_MOVE, boards cleared, turn=~FIRST_X (FIRST_X=1 gives turn=0), timeout counter=0.
REQ-021 WAIT_MOVE: move_ready=1; handshake = move_valid & move_ready at a rising edge.
REQ-022 A move is legal iff move_player==turn, move_pos<=8, and x_board[move_pos]==0 and o_board[move_pos]==0.
REQ-023 Legal handshake: set the mover's board bit at that edge; move_ack=1 the following cycle; state -> EVAL.
REQ-024 Illegal handshake: boards and turn unchanged; move_err=1 the following cycle; stay in WAIT_MOVE; timeout counter not cleared.
REQ-025 EVAL (exactly 1 cycle, move_ready=0): check the registered boards for 8 lines (3 rows, 3 columns, 2 diagonals).
REQ-026 EVAL outcome: mover has a line -> DONE, winner = mover. Else all 9 cells occupied -> DONE, winner=11. Else toggle turn, clear timeout counter, go to WAIT_MOVE.
REQ-027 Latency: handshake edge N; board updated and move_ack at N+1 (EVAL); move_ready=1 or game_over=1 at N+2.
REQ-028 Timeout counter: 16-bit, increments each WAIT_MOVE cycle without a legal handshake.
REQ-029 When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no legal handshake that cycle: go to DONE, winner = opponent of turn, forfeit=1.
REQ-030 A legal handshake in the same cycle as timeout expiry SHALL win; the move is taken and no forfeit occurs.
REQ-031 DONE: move_ready=0; boards, winner and forfeit held until start or rst.
REQ-032 start SHALL apply in any state, override a coincident handshake (move ignored, no ack/err), and clear winner, forfeit, boards and counter.
REQ-033 A mid-game start acts identically to start from IDLE.
REQ-034 Only a player who made a legal move can win; both boards holding lines is unreachable through the handshake.

Reset
REQ-035 rst SHALL have priority over start and all moves, in any state including mid-EVAL.
REQ-036 rst -> state IDLE, x_board=0, o_board=0, turn=0, winner=00, forfeit=0, game_over=0, move_ack=0, move_err=0, move_ready=0, counter=0.

Verification
REQ-037 X win: FIRST_X=1, start; moves X4, O0, X2, O1, X6 -> after last ack, winner=01, game_over=1, x_board=0x054, o_board=0x003.
REQ-038 Draw: moves X0 O1 X2 O4 X3 O5 X7 O6 X8 -> winner=11, forfeit=0, x_board=0x18D, o_board=0x072.
REQ-039 Illegal moves: occupied cell, pos=9, wrong player -> each gives move_err pulse 1 cycle later, boards and turn unchanged, move_ack=0.
REQ-040 Timeout: TIMEOUT=5, start, no moves -> DONE 5 cycles after entering WAIT_MOVE, winner=10, forfeit=1; legal move on expiry cycle -> accepted, forfeit=0.
REQ-041 Start and rst: start coincident with a legal handshake mid-game -> boards 0, no ack, WAIT_MOVE; rst during EVAL -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/tictactoe_ctrl.sv
// -----------------------------------------------------------------------------
// tictactoe_ctrl
// Two-player tic-tac-toe referee. Accepts moves through a valid/ready
// handshake, rejects illegal ones, checks for a winning line or a full board
// one cycle after every committed move, and ends the game by forfeit when the
// player to move stalls for TIMEOUT cycles.
//
// Parameters
//   FIRST_X     1 = X opens the game, 0 = O opens the game
//   TIMEOUT     per-move cycle limit (1..65535), 0 disables the forfeit timer
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous active-high reset, highest priority
//   start       one-cycle pulse: clear the board and begin a new game
//   move_valid  move request present
//   move_player requesting player (0 = X, 1 = O)
//   move_pos    target cell 0..8, row-major; bit i of the boards is cell i
//   move_ready  a move can be accepted this cycle
//   move_ack    one-cycle pulse: legal move committed
//   move_err    one-cycle pulse: move rejected
//   x_board     cells held by X
//   o_board     cells held by O
//   turn        player to move (0 = X, 1 = O)
//   game_over   high while the game is finished
//   winner      00 none, 01 X, 10 O, 11 draw (valid while game_over)
//   forfeit     high when the finished game ended by timeout
// -----------------------------------------------------------------------------
module tictactoe_ctrl #(
   parameter bit          FIRST_X = 1'b1,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       move_valid,
   input  logic       move_player,
   input  logic [3:0] move_pos,
   output logic       move_ready,
   output logic       move_ack,
   output logic       move_err,
   output logic [8:0] x_board,
   output logic [8:0] o_board,
   output logic       turn,
   output logic       game_over,
   output logic [1:0] winner,
   output logic       forfeit
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_MOVE = 2'd1,
      EVAL      = 2'd2,
      DONE      = 2'd3
   } state_t;

   localparam bit          TIMEOUT_EN   = (TIMEOUT != 32'd0);
   localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT - 32'd1) : 16'd0;

   // True when the board holds any of the eight winning lines.
   function automatic logic has_line(input logic [8:0] b);
      has_line = (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
                 (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
                 (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
   endfunction

   state_t      state_r, state_s;
   logic [8:0]  x_board_r, x_board_s;
   logic [8:0]  o_board_r, o_board_s;
   logic        turn_r, turn_s;
   logic [1:0]  winner_r, winner_s;
   logic        forfeit_r, forfeit_s;
   logic        move_ack_r, move_ack_s;
   logic        move_err_r, move_err_s;
   logic        move_ready_r, move_ready_s;
   logic        game_over_r, game_over_s;
   logic [15:0] cnt_r, cnt_s;

   logic [8:0]  occ_s;
   logic [15:0] occ16_s;
   logic [8:0]  mask_s;
   logic [8:0]  mover_board_s;
   logic        legal_s;

   // Legality of the presented move and the cell mask it would set.
   always_comb begin
      occ_s         = x_board_r | o_board_r;
      occ16_s       = {7'd0, occ_s};          // widened so pos 9..15 indexes safely
      mask_s        = 9'd1 << move_pos;
      mover_board_s = turn_r ? o_board_r : x_board_r;
      legal_s       = (move_player == turn_r) && (move_pos <= 4'd8) && !occ16_s[move_pos];
   end

   // Next-state and next-output decode; start overrides everything but rst.
   always_comb begin
      state_s    = state_r;
      x_board_s  = x_board_r;
      o_board_s  = o_board_r;
      turn_s     = turn_r;
      winner_s   = winner_r;
      forfeit_s  = forfeit_r;
      cnt_s      = cnt_r;
      move_ack_s = 1'b0;
      move_err_s = 1'b0;
      if (start) begin
         state_s   = WAIT_MOVE;
         x_board_s = 9'd0;
         o_board_s = 9'd0;
         turn_s    = ~FIRST_X;
         winner_s  = 2'b00;
         forfeit_s = 1'b0;
         cnt_s     = 16'd0;
      end else begin
         case (state_r)
            IDLE: begin
               state_s = IDLE;
            end
            WAIT_MOVE: begin
               if (move_valid && legal_s) begin
                  // A legal move wins over a coincident timeout expiry.
                  if (turn_r == 1'b0) begin
                     x_board_s = x_board_r | mask_s;
                  end else begin
                     o_board_s = o_board_r | mask_s;
                  end
                  move_ack_s = 1'b1;
                  state_s    = EVAL;
               end else begin
                  move_err_s = move_valid;
                  if (TIMEOUT_EN && (cnt_r == TIMEOUT_LAST)) begin
                     state_s   = DONE;
                     winner_s  = turn_r ? 2'b01 : 2'b10;
                     forfeit_s = 1'b1;
                  end else begin
                     cnt_s = cnt_r + 16'd1;
                  end
               end
            end
            EVAL: begin
               // Only the player who just moved can have completed a line.
               if (has_line(mover_board_s)) begin
                  state_s  = DONE;
                  winner_s = turn_r ? 2'b10 : 2'b01;
               end else if (occ_s == 9'h1FF) begin
                  state_s  = DONE;
                  winner_s = 2'b11;
               end else begin
                  state_s = WAIT_MOVE;
                  turn_s  = ~turn_r;
                  cnt_s   = 16'd0;
               end
            end
            DONE: begin
               state_s = DONE;
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
      move_ready_s = (state_s == WAIT_MOVE);
      game_over_s  = (state_s == DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         x_board_r    <= 9'd0;
         o_board_r    <= 9'd0;
         turn_r       <= 1'b0;
         winner_r     <= 2'b00;
         forfeit_r    <= 1'b0;
         cnt_r        <= 16'd0;
         move_ack_r   <= 1'b0;
         move_err_r   <= 1'b0;
         move_ready_r <= 1'b0;
         game_over_r  <= 1'b0;
      end else begin
         state_r      <= state_s;
         x_board_r    <= x_board_s;
         o_board_r    <= o_board_s;
         turn_r       <= turn_s;
         winner_r     <= winner_s;
         forfeit_r    <= forfeit_s;
         cnt_r        <= cnt_s;
         move_ack_r   <= move_ack_s;
         move_err_r   <= move_err_s;
         move_ready_r <= move_ready_s;
         game_over_r  <= game_over_s;
      end
   end

   assign move_ready = move_ready_r;
   assign move_ack   = move_ack_r;
   assign move_err   = move_err_r;
   assign x_board    = x_board_r;
   assign o_board    = o_board_r;
   assign turn       = turn_r;
   assign game_over  = game_over_r;
   assign winner     = winner_r;
   assign forfeit    = forfeit_r;

endmodule
